chacha_block_core: RTL and testbench
====================================

# chacha_block_core

Parametrised ChaCha block-function engine: the next generation of the byte-addressed ChaCha block behind the tile's pin interface. A host loads the 16-word input state one byte at a time, pulses `start`, and reads back the 64-byte keystream block. It adds a configurable round count, an explicit `start`/`done` handshake and optional block-counter auto-increment for back-to-back keystream generation. It sits directly under the tile top, which maps pins onto these ports.

## Interface
- `ROUNDS`, 20, total ChaCha rounds; legal values are 8, 12 and 20; any other value is an elaboration error.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: reset; synchronous, active-high.
- `data_in` input 8: write byte.
- `addr_in` input 6: byte address. Word index is `addr_in[5:2]`; byte lane is `addr_in[1:0]`, little-endian.
- `write` input 1: byte write strobe.
- `start` input 1: begin a block computation.
- `data_out` output 8: read byte of the result block.
- `ready` output 1: idle, results valid, writes accepted.
- `done` output 1: one-cycle pulse when a block completes.

## Operation
- Storage:
  - `in_state`: 16×32 input words.
  - `work`: 16×32 working and result words.
- FSM states are IDLE, ROUND and FINAL.
- **IDLE:**
  - `ready`=1.
  - When `write`=1 and `start`=0, byte `addr_in[1:0]` of `in_state[addr_in[5:2]]` is set to `data_in`.
  - When `start`=1: `work` ← `in_state`, the step counter ← 0, and the FSM moves to ROUND.
  - When `start` and `write` are both 1, `start` wins and the write is dropped.
- **ROUND:**
  - One quarter-round per cycle on `work`, index `q` = step mod 8:
    - Column rounds: q0 (0,4,8,12), q1 (1,5,9,13), q2 (2,6,10,14), q3 (3,7,11,15).
    - Diagonal rounds: q4 (0,5,10,15), q5 (1,6,11,12), q6 (2,7,8,13), q7 (3,4,9,14).
  - Quarter-round on (a,b,c,d), all arithmetic mod 2^32:
    - a+=b; d^=a; d<<<=16
    - c+=d; b^=c; b<<<=12
    - a+=b; d^=a; d<<<=8
    - c+=d; b^=c; b<<<=7
  - After step 4·ROUNDS−1 the FSM moves to FINAL.
- **FINAL:**
  - `work[i]` ← `work[i]` + `in_state[i]` (mod 2^32) for all 16 words.
  - Auto-increment is applied here when it is compiled in (see Configuration).
  - The FSM then moves to IDLE, and `done` is registered high for exactly one cycle.
- Reads are combinational:
  - When `ready`=1, `data_out` = byte `addr_in[1:0]` of `work[addr_in[5:2]]`.
  - When `ready`=0, `data_out` = 0.
- While busy, `write` and `start` are ignored and `in_state` is frozen.
- Constants in words 0–3 are host-written; none are hardwired.

## Timing
- Reset values:
  - FSM = IDLE, `ready`=1, `done`=0, `data_out`=0.
  - `in_state` = 0, `work` = 0, step counter = 0.
- Latency:
  - `start` is sampled at edge N.
  - `ready` is 0 from after edge N until after edge N+4·ROUNDS+1.
  - `ready` and `done` both rise after edge N+4·ROUNDS+1, which is 81 cycles for ROUNDS=20 and 33 for ROUNDS=8.
  - The result is readable in the same cycle `done` is high.
- The step counter is `$clog2(4*ROUNDS)` bits wide.
- A new `start` is legal in the same cycle `done` is high.
- Reset asserted mid-computation:
  - The FSM returns to IDLE and both arrays clear on that edge.
  - No `done` pulse is produced.
- Only the first edge of a multi-cycle `start` is acted on while IDLE. A `start` still held when the FSM returns to IDLE launches another block.

## Configuration
- `CHACHA_CTR_AUTOINC_EN`:
  - **Defined:** in FINAL, `in_state[12]` ← `in_state[12]`+1, wrapping 0xFFFFFFFF→0. There is no carry into word 13. Consecutive `start`s therefore produce consecutive keystream blocks without host rewrites.
  - **Undefined:** `in_state` is never modified by the core. The increment logic is absent.

## Test plan
- **Reset state:** assert `rst` for 1 cycle, then read all 64 addresses. Required: `ready`=1, `done`=0, every byte 0x00.
- **All-zero state:** `start` with ROUNDS=20. Required: `done` is observed exactly 81 cycles after the `start` edge, and all 64 output bytes are 0x00.
- **RFC 8439 §2.3.2 vector:**
  - Load the constants, key bytes 00..1f, counter=1 and nonce 00 00 00 09 00 00 00 4a 00 00 00 00.
  - Run `start` with ROUNDS=20.
  - Required: bytes 0..15 read 10 f1 e7 e4 d1 3b 59 15 50 0f dd 1f a3 20 71 c4. All 64 bytes match the RFC.
- **Busy protection:** mid-run, drive `write` to address 0x30 with 0xAA, and pulse `start`. Required: the result is unchanged versus the clean run, and exactly one `done` pulse occurs.
- **Auto-increment (macro defined):**
  - A second `start` after the RFC run must equal a reference-model block for counter=2.
  - With counter=0xFFFFFFFF, the next block must use counter 0 with word 13 unchanged.
  - With the macro undefined, a second run reproduces block 1 exactly.
- **Reset mid-run:** assert `rst` at step 10. Required: `ready`=1 on the next cycle, no `done`, and all reads 0x00.

Source files
------------

// File: rtl/chacha_block_core_if.sv
// Host-side pin bundle of the ChaCha block engine: byte-wide load/read port plus start/done handshake.
interface chacha_block_core_if;
  logic [7:0] data_in;
  logic [5:0] addr_in;
  logic       write;
  logic       start;
  logic [7:0] data_out;
  logic       ready;
  logic       done;

  modport master (
    output data_in, addr_in, write, start,
    input  data_out, ready, done
  );

  modport slave (
    input  data_in, addr_in, write, start,
    output data_out, ready, done
  );
endinterface

// File: rtl/chacha_block_core.sv
// ChaCha block engine: one quarter-round per clock over a 16x32 working array, final feed-forward add.
// Optional macro CHACHA_CTR_AUTOINC_EN bumps the block counter (word 12) after every block.
module chacha_block_core #(
  parameter int unsigned ROUNDS = 20
) (
  input logic          clk,
  input logic          rst,
  chacha_block_core_if.slave bus
);

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned N_WORDS = 16;
  localparam int unsigned STEPS   = 4 * ROUNDS;
  localparam int unsigned STEP_W  = $clog2(STEPS);

  generate
    if ((ROUNDS != 8) && (ROUNDS != 12) && (ROUNDS != 20)) begin : g_bad_rounds
      $error("chacha_block_core: ROUNDS must be 8, 12 or 20");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [WORD_W-1:0]   in_state [N_WORDS];
  logic [WORD_W-1:0]   work     [N_WORDS];
  logic [WORD_W-1:0]   work_qr  [N_WORDS];
  logic [STEP_W-1:0]   step;
  logic                ready_q;
  logic                done_q;
  logic                last_step;

  logic [2:0]          q;
  logic [3:0]          ia, ib, ic, id;
  logic [WORD_W-1:0]   a0, b0, c0, d0;
  logic [WORD_W-1:0]   a1, b1, c1, d1;
  logic [WORD_W-1:0]   a2, b2, c2, d2;
  logic [WORD_W-1:0]   t16, t12, t8, t7;
  logic [WORD_W-1:0]   rd_word;

  assign q         = step[2:0];
  assign last_step = (step == STEP_W'(STEPS - 1));

  // Word selection: columns for q<4, diagonals (lanes rotated by 1/2/3) for q>=4
  always_comb begin
    ia = {2'b00, q[1:0]};
    ib = {2'b01, q[1:0]};
    ic = {2'b10, q[1:0]};
    id = {2'b11, q[1:0]};
    if (q[2]) begin
      ib = {2'b01, q[1:0] + 2'd1};
      ic = {2'b10, q[1:0] + 2'd2};
      id = {2'b11, q[1:0] + 2'd3};
    end
  end

  // One full quarter-round on the selected words
  always_comb begin
    a0  = work[ia];
    b0  = work[ib];
    c0  = work[ic];
    d0  = work[id];
    a1  = a0 + b0;
    t16 = d0 ^ a1;
    d1  = {t16[15:0], t16[31:16]};
    c1  = c0 + d1;
    t12 = b0 ^ c1;
    b1  = {t12[19:0], t12[31:20]};
    a2  = a1 + b1;
    t8  = d1 ^ a2;
    d2  = {t8[23:0], t8[31:24]};
    c2  = c1 + d2;
    t7  = b1 ^ c2;
    b2  = {t7[24:0], t7[31:25]};
  end

  always_comb begin
    for (int i = 0; i < N_WORDS; i++) begin
      work_qr[i] = work[i];
    end
    work_qr[ia] = a2;
    work_qr[ib] = b2;
    work_qr[ic] = c2;
    work_qr[id] = d2;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = ROUND;
      ROUND:   if (last_step) state_nxt = FINAL;
      FINAL:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake flags, registered from the FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      ready_q <= (state_nxt == IDLE);
      done_q  <= (state == FINAL);
    end
  end

  // Input/working arrays and step counter; start beats a same-cycle write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_WORDS; i++) begin
        in_state[i] <= '0;
        work[i]     <= '0;
      end
      step <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            for (int i = 0; i < N_WORDS; i++) begin
              work[i] <= in_state[i];
            end
            step <= '0;
          end else if (bus.write) begin
            in_state[bus.addr_in[5:2]][{bus.addr_in[1:0], 3'b000} +: 8] <= bus.data_in;
          end
        end
        ROUND: begin
          for (int i = 0; i < N_WORDS; i++) begin
            work[i] <= work_qr[i];
          end
          step <= step + STEP_W'(1);
        end
        FINAL: begin
          for (int i = 0; i < N_WORDS; i++) begin
            work[i] <= work[i] + in_state[i];
          end
`ifdef CHACHA_CTR_AUTOINC_EN
          in_state[12] <= in_state[12] + WORD_W'(1);
`else
`endif
        end
        default: begin
          step <= '0;
        end
      endcase
    end
  end

  // Combinational byte read, gated to zero while busy
  always_comb begin
    rd_word = work[bus.addr_in[5:2]];
  end

  assign bus.data_out = ready_q ? rd_word[{bus.addr_in[1:0], 3'b000} +: 8] : 8'h00;
  assign bus.ready    = ready_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_chacha_block_core.sv
// Scoreboard bench for chacha_block_core: expected blocks queued at start, checked at done.
module tb_chacha_block_core;

  localparam int unsigned ROUNDS = 20;
  localparam int unsigned LAT    = 4 * ROUNDS + 1;

  typedef logic [15:0][31:0] blk_t;

  logic clk = 1'b0;
  logic rst;
  int   errors    = 0;
  int   checks    = 0;
  int   done_seen = 0;
  blk_t host;
  blk_t sb [$];

  always #5 clk = ~clk;

  chacha_block_core_if bus ();

  chacha_block_core #(.ROUNDS(ROUNDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(negedge clk) if (bus.done === 1'b1) done_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic blk_t qr_m(input blk_t x, input int a, input int b, input int c, input int d);
    x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 16);
    x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 12);
    x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 8);
    x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 7);
    return x;
  endfunction

  function automatic blk_t chacha_model(input blk_t s);
    blk_t x = s;
    blk_t o;
    for (int r = 0; r < int'(ROUNDS); r += 2) begin
      x = qr_m(x, 0, 4, 8, 12);
      x = qr_m(x, 1, 5, 9, 13);
      x = qr_m(x, 2, 6, 10, 14);
      x = qr_m(x, 3, 7, 11, 15);
      x = qr_m(x, 0, 5, 10, 15);
      x = qr_m(x, 1, 6, 11, 12);
      x = qr_m(x, 2, 7, 8, 13);
      x = qr_m(x, 3, 4, 9, 14);
    end
    for (int i = 0; i < 16; i++) o[i] = x[i] + s[i];
    return o;
  endfunction

  function automatic logic [7:0] blk_byte(input blk_t b, input int a);
    logic [31:0] w = b[a / 4];
    return w[8 * (a % 4) +: 8];
  endfunction

  task automatic write_byte(input int a, input logic [7:0] v);
    @(negedge clk);
    bus.addr_in = 6'(a);
    bus.data_in = v;
    bus.write   = 1'b1;
    @(negedge clk);
    bus.write   = 1'b0;
  endtask

  task automatic load_host();
    for (int a = 0; a < 64; a++) write_byte(a, blk_byte(host, a));
  endtask

  task automatic read_all(input string tag, input blk_t exp);
    for (int a = 0; a < 64; a++) begin
      @(negedge clk);
      bus.addr_in = 6'(a);
      #1;
      check($sformatf("%s[%0d]", tag, a), 32'(bus.data_out), 32'(blk_byte(exp, a)));
    end
  endtask

  task automatic set_rfc();
    host[0]  = 32'h61707865; host[1]  = 32'h3320646e;
    host[2]  = 32'h79622d32; host[3]  = 32'h6b206574;
    for (int i = 0; i < 8; i++)
      host[4 + i] = {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)};
    host[12] = 32'h00000001; host[13] = 32'h09000000;
    host[14] = 32'h4a000000; host[15] = 32'h00000000;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic run_block(input string tag, input bit inject);
    int   cnt;
    bit   got;
    int   d0;
    blk_t exp;
    sb.push_back(chacha_model(host));
`ifdef CHACHA_CTR_AUTOINC_EN
    host[12] = host[12] + 32'd1;
`endif
    d0 = done_seen;
    pulse_start();
    check({tag, "_busy_ready"}, 32'(bus.ready), 32'd0);
    cnt = 0;
    got = 1'b0;
    while (cnt < 300 && !got) begin
      @(posedge clk);
      cnt++;
      #1;
      if (bus.done === 1'b1) got = 1'b1;
      else if (inject && cnt == 20) begin
        bus.addr_in = 6'h30; bus.data_in = 8'hAA; bus.write = 1'b1; bus.start = 1'b1;
      end else if (inject && cnt == 21) begin
        bus.write = 1'b0; bus.start = 1'b0;
      end
    end
    bus.write = 1'b0;
    bus.start = 1'b0;
    check({tag, "_latency"}, 32'(cnt), 32'(LAT));
    check({tag, "_done_ready"}, 32'(bus.ready), 32'd1);
    exp = sb.pop_front();
    read_all(tag, exp);
    check({tag, "_done_pulses"}, 32'(done_seen - d0), 32'd1);
  endtask

  initial begin
    logic [7:0] rfc16 [16];
    blk_t zero;
    int   d0;
    rfc16 = '{8'h10, 8'hf1, 8'he7, 8'he4, 8'hd1, 8'h3b, 8'h59, 8'h15,
              8'h50, 8'h0f, 8'hdd, 8'h1f, 8'ha3, 8'h20, 8'h71, 8'hc4};
    zero        = '0;
    host        = '0;
    bus.data_in = '0;
    bus.addr_in = '0;
    bus.write   = 1'b0;
    bus.start   = 1'b0;
    rst         = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    read_all("rst", zero);

    run_block("zero", 1'b0);

    set_rfc();
    load_host();
    run_block("rfc", 1'b0);
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      bus.addr_in = 6'(a);
      #1;
      check($sformatf("rfc_lit[%0d]", a), 32'(bus.data_out), 32'(rfc16[a]));
    end
    run_block("rfc_next", 1'b0);

    set_rfc();
    load_host();
    run_block("busy", 1'b1);

    host[12] = 32'hFFFFFFFF;
    load_host();
    run_block("wrap1", 1'b0);
    run_block("wrap2", 1'b0);

    // Reset landing while step 10 is pending
    sb.push_back(chacha_model(host));
    d0 = done_seen;
    pulse_start();
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(sb.pop_front());
    host = '0;
    check("midrst_ready", 32'(bus.ready), 32'd1);
    check("midrst_done", 32'(bus.done), 32'd0);
    repeat (100) @(posedge clk);
    check("midrst_no_done", 32'(done_seen - d0), 32'd0);
    read_all("midrst", zero);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
